// File: rtl/pipelined_param_adder.sv
// pipelined_param_adder
// WIDTH-bit add/subtract with carry/borrow-in. The carry chain is cut into
// SEG-bit segments with one register stage per segment, so a beat takes
// STAGES = WIDTH/SEG cycles and one beat is accepted per cycle. A single
// global advance signal stalls every stage at once. Flow control on both
// sides uses valid/ready.
module pipelined_param_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // SEG_SAFE keeps the derived constants computable when SEG is illegal, so
  // that the elaboration error below is the message the user sees.
  localparam int SEG_SAFE = (SEG < 1) ? 1 : SEG;
  localparam int STAGES   = WIDTH / SEG_SAFE;
  localparam int LAST     = STAGES - 1;

  if (SEG < 1) begin : g_bad_seg
    $error("pipelined_param_adder: SEG must be at least 1");
  end else if ((WIDTH % SEG) != 0) begin : g_bad_width
    $error("pipelined_param_adder: WIDTH must be a multiple of SEG");
  end

  // Result of one segment of the carry chain. cmsb is the carry into the
  // segment's top bit. Only the last stage keeps it, for signed overflow.
  typedef struct packed {
    logic [SEG_SAFE-1:0] s;
    logic                cout;
    logic                cmsb;
  } seg_res_t;

  // Bit-level ripple across one segment. The carry into the top bit is
  // returned as well as the carry out.
  function automatic seg_res_t seg_add(input logic [SEG_SAFE-1:0] x,
                                       input logic [SEG_SAFE-1:0] y,
                                       input logic                ci);
    seg_res_t r;
    logic     c;
    r = '0;
    c = ci;
    for (int i = 0; i < SEG_SAFE; i++) begin
      if (i == SEG_SAFE - 1) r.cmsb = c;
      r.s[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    r.cout = c;
    return r;
  endfunction

  // Per-stage state. Stage k holds the full operand words, so the upper
  // segments are still available to later stages. It also holds the result
  // bits resolved so far and the carry out of its own segment.
  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic             cmsb_q;
  logic             cmsb_d;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Stage-input selection scratch used inside the next-state block.
  logic             src_valid;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] src_sum;
  logic             src_c;
  seg_res_t         res;

  // Subtraction is a + ~b + ~borrow. The borrow-in becomes an inverted carry-in.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? ~cin : cin;

  // All stages move together. A full output slot that is not being taken
  // freezes the whole pipe. in_ready does not depend on in_valid.
  assign advance  = !valid_q[LAST] || out_ready;
  assign in_ready = advance;

  assign out_valid = valid_q[LAST];
  assign sum       = sum_q[LAST];
  assign cout      = carry_q[LAST];
  assign ovf       = cmsb_q ^ carry_q[LAST];

  // Next state of every stage: hold when stalled, otherwise take the
  // previous stage (or the input port) and resolve one more segment.
  always_comb begin
    // NOTE: every variable written here gets a default first so that no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    src_valid = 1'b0;
    src_a     = '0;
    src_b     = '0;
    src_sum   = '0;
    src_c     = 1'b0;
    res       = '0;
    cmsb_d    = cmsb_q;
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = valid_q[k];
      a_d[k]     = a_q[k];
      b_d[k]     = b_q[k];
      sum_d[k]   = sum_q[k];
      carry_d[k] = carry_q[k];
    end

    if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        if (k == 0) begin
          src_valid = in_valid;
          src_a     = a;
          src_b     = b_eff;
          src_sum   = '0;
          src_c     = c_eff;
        end else begin
          src_valid = valid_q[k-1];
          src_a     = a_q[k-1];
          src_b     = b_q[k-1];
          src_sum   = sum_q[k-1];
          src_c     = carry_q[k-1];
        end

        res = seg_add(src_a[k*SEG_SAFE +: SEG_SAFE],
                      src_b[k*SEG_SAFE +: SEG_SAFE], src_c);

        valid_d[k]                         = src_valid;
        a_d[k]                             = src_a;
        b_d[k]                             = src_b;
        sum_d[k]                           = src_sum;
        sum_d[k][k*SEG_SAFE +: SEG_SAFE]   = res.s;
        carry_d[k]                         = res.cout;
        if (k == LAST) cmsb_d              = res.cmsb;
      end
    end
  end

  // Pipeline registers. Asynchronous reset clears valid bits and data alike.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data arrays are reset as well as the valid bits. This makes
      // sum/cout/ovf read zero from reset and keeps X out of the datapath.
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
      cmsb_q <= 1'b0;
    end else begin
      // NOTE: use non-blocking assignments here. Every stage then samples the
      // previous stage's old value, which is what makes this a pipeline.
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
      end
      cmsb_q <= cmsb_d;
    end
  end

endmodule

// File: doc/pipelined_param_adder.md
Name: pipelined_param_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit parallel adder.
- Adds or subtracts two WIDTH-bit operands with carry/borrow-in.
- Carry chain is split into SEG-bit segments, one register stage per segment; accepts one operation per cycle.
- Valid/ready handshake on both sides, so it drops into streaming datapaths with backpressure.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage.
- STAGES, WIDTH/SEG, derived localparam; pipeline latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0 = a+b+cin; 1 = a-b-cin.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  add: carry-out; sub: 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (async assert, sync release):
  - All stage valid bits = 0; out_valid = 0; sum = 0; cout = 0; ovf = 0.
  - All stored operand, partial-sum and carry registers = 0.
- Operand conditioning at entry:
  - b_eff = sub ? ~b : b.
  - c_eff = sub ? ~cin : cin.
- Pipeline: stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of a and b_eff plus the carry from stage k-1 (stage 0 uses c_eff).
  - Stage k registers its SEG result bits, its carry-out, and the still-unused upper operand bits.
  - Lower result bits produced by earlier stages propagate unchanged alongside.
- Outputs:
  - Final stage drives sum, cout = carry out of bit WIDTH-1, and ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - The MSB carry-in is captured inside the last stage.
- Latency: a beat accepted at edge N (in_valid & in_ready) appears with out_valid = 1 after edge N+STAGES-1 when no stalls occur, i.e. STAGES register stages.
- Throughput: one beat per cycle while out_ready = 1.
- Handshake and flow control:
  - Global stall, shared by all stages: advance = !out_valid | out_ready; in_ready = advance.
  - No combinational path from in_valid to in_ready.
  - When advance = 0, every stage register and valid bit holds; sum/cout/ovf stay stable while out_valid = 1 and out_ready = 0.
  - in_valid with in_ready = 0: beat not taken; the source must hold it.
  - Bubbles (in_valid = 0 while advancing) insert a stage valid of 0; data registers in invalid stages may update but are don't-care.
  - Output is transferred on out_valid & out_ready; with advance = 1 the next pipeline beat, or a bubble, loads the same edge.
- Boundary cases:
  - All-ones + all-ones + cin=1 gives sum = all-ones, cout = 1.
  - Sub with a = b, cin = 0 gives sum = 0, cout = 1, ovf = 0.
  - Carry crossing every segment boundary must be exact: 0x0FFF + 0x0001 gives 0x1000.
- Reset mid-operation: all in-flight beats are discarded, none emerge after release, and the first accepted beat after release has normal latency.
- Parameter check: WIDTH % SEG != 0 or SEG < 1 is an elaboration error. SEG = WIDTH gives a single-stage adder with latency 1.

Test Plan (WIDTH=16, SEG=4, latency 4):
- Exhaustive low nibble: sweep a[3:0], b[3:0] over 0..15 with upper bits 0, cin=0, out_ready=1 → sum = a+b, cout = 0, one result per cycle, first out_valid 4 cycles after the first accept.
- Ripple across segments: a=0xFFFF, b=0x0001, cin=0, sub=0 → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, cin=0, sub=1 → sum=0xFFFE, cout=0. Then a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1. Then a=b=0x1234, cin=1, sub=1 → sum=0xFFFF, cout=0.
- Backpressure: stream 8 random beats, hold out_ready=0 for 3 cycles mid-stream → in_ready=0 throughout, sum/cout/ovf held stable, no beat lost or duplicated, order preserved versus a reference model.
- Bubbles: alternate in_valid 1/0 over 6 cycles → out_valid pattern equals the input pattern delayed 4 cycles.
- Reset mid-flight: accept 3 beats, assert rst_n=0 for one cycle asynchronously (between edges) → out_valid=0 and sum=0 immediately. After release, none of the 3 beats emerge; a new beat 0x0001+0x0002 yields 0x0003 four cycles after its accept.
